// File: rtl/time_entry_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : time_entry_pkg
//  Description : Shared types and constants for the oven time-entry keypad
//                front end (FSM states, BCD digit type, key vector layout).
//  Revision    : 1.0 - initial release
// ============================================================================
package time_entry_pkg;

    localparam int DIGIT_W                 = 4;
    localparam int SEC_TENS_MAX            = 5;
    localparam int DEBOUNCE_CYCLES_DEFAULT = 4;

    // Key vector layout: digit keys in [9:0], then clear, then start.
    localparam int NUM_DIGIT_KEYS = 10;
    localparam int KEY_CLEAR      = 10;
    localparam int KEY_START      = 11;
    localparam int KEY_W          = 12;

    typedef logic [DIGIT_W-1:0] digit_t;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_DEBOUNCE     = 2'd1,
        ST_WAIT_RELEASE = 2'd2,
        ST_LOAD         = 2'd3
    } state_e;

    // True when exactly one digit key is pressed.
    function automatic logic is_onehot(input logic [NUM_DIGIT_KEYS-1:0] v);
        return (v != '0) && ((v & (v - 1'b1)) == '0);
    endfunction

    // Index of the (single) pressed digit key.
    function automatic digit_t key_to_digit(input logic [NUM_DIGIT_KEYS-1:0] v);
        digit_t d;
        d = '0;
        for (int i = 0; i < NUM_DIGIT_KEYS; i++) begin
            if (v[i]) d = digit_t'(i);
        end
        return d;
    endfunction

endpackage : time_entry_pkg
`default_nettype wire

// File: rtl/time_entry_if.sv
`default_nettype none
// ============================================================================
//  Module      : time_entry_if
//  Description : Key inputs and timer-counter load outputs of the time-entry
//                block. master = key/controller side, slave = time_entry.
//  Revision    : 1.0 - initial release
// ============================================================================
interface time_entry_if;
    import time_entry_pkg::*;

    logic [NUM_DIGIT_KEYS-1:0] keypad;
    logic                      clear_key;
    logic                      start_key;
    logic                      entry_en;
    digit_t                    sec_ones;
    digit_t                    sec_tens;
    digit_t                    min_ones;
    logic                      loadn;
    logic                      key_ack;
    logic                      key_rej;
    logic                      nonzero;

    modport master (
        output keypad, clear_key, start_key, entry_en,
        input  sec_ones, sec_tens, min_ones, loadn, key_ack, key_rej, nonzero
    );

    modport slave (
        input  keypad, clear_key, start_key, entry_en,
        output sec_ones, sec_tens, min_ones, loadn, key_ack, key_rej, nonzero
    );

endinterface : time_entry_if
`default_nettype wire

// File: rtl/time_entry_key_sync_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : key_sync_debounce
//  Description : Two-flop synchronizer on every raw key plus one debounce
//                counter on the OR of the synchronized keys. Reports whether
//                "any key" has held its level for DEBOUNCE_CYCLES cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module key_sync_debounce #(
    parameter int KEY_W           = 12,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  wire logic             clk,
    input  wire logic             clrn,
    input  wire logic [KEY_W-1:0] key_raw,
    output logic      [KEY_W-1:0] key_sync,
    output logic                  key_any,
    output logic                  press_stable,
    output logic                  release_stable
);

    localparam int                CNT_W     = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  C_CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

    logic [KEY_W-1:0] sync1_q, sync1_d;
    logic [KEY_W-1:0] sync2_q, sync2_d;
    logic             any_q,   any_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             w_any;

    // Synchronizer chain, level history and run-length counter.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            sync1_q <= '0;
            sync2_q <= '0;
            any_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            any_q   <= any_d;
            cnt_q   <= cnt_d;
        end
    end

    // cnt_d is the run length of the current level including this cycle,
    // saturating at the debounce threshold.
    always_comb begin
        sync1_d = key_raw;
        sync2_d = sync1_q;
        w_any   = |sync2_q;
        any_d   = w_any;
        if (w_any != any_q) begin
            cnt_d = CNT_W'(1);
        end else if (cnt_q == C_CNT_MAX) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
        key_sync       = sync2_q;
        key_any        = w_any;
        press_stable   =  w_any && (cnt_d == C_CNT_MAX);
        release_stable = !w_any && (cnt_d == C_CNT_MAX);
    end

endmodule : key_sync_debounce
`default_nettype wire

// File: rtl/time_entry.sv
`default_nettype none
// ============================================================================
//  Module      : time_entry
//  Description : Microwave time-entry front end. Debounced digit keys shift
//                into an M:S:S BCD register; clear zeroes it; start pulses
//                loadn for one cycle to load the timer counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module time_entry
    import time_entry_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  wire logic clk,
    input  wire logic clrn,
    time_entry_if.slave bus
);

    state_e             state_q, state_d;
    digit_t             sec_ones_q, sec_ones_d;
    digit_t             sec_tens_q, sec_tens_d;
    digit_t             min_ones_q, min_ones_d;

    logic [KEY_W-1:0]   w_key_sync;
    logic               w_key_any;
    logic               w_press_stable;
    logic               w_release_stable;
    logic               w_key_ack;
    logic               w_key_rej;
    logic               w_nonzero;
    logic [NUM_DIGIT_KEYS-1:0] w_digits;

    key_sync_debounce #(
        .KEY_W           (KEY_W),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_key_sync_debounce (
        .clk            (clk),
        .clrn           (clrn),
        .key_raw        ({bus.start_key, bus.clear_key, bus.keypad}),
        .key_sync       (w_key_sync),
        .key_any        (w_key_any),
        .press_stable   (w_press_stable),
        .release_stable (w_release_stable)
    );

    // State and digit registers.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q    <= ST_IDLE;
            sec_ones_q <= '0;
            sec_tens_q <= '0;
            min_ones_q <= '0;
        end else begin
            state_q    <= state_d;
            sec_ones_q <= sec_ones_d;
            sec_tens_q <= sec_tens_d;
            min_ones_q <= min_ones_d;
        end
    end

    // Next state, digit update and acknowledge pulses; the key action is
    // taken in the same cycle the press is accepted.
    always_comb begin
        state_d    = state_q;
        sec_ones_d = sec_ones_q;
        sec_tens_d = sec_tens_q;
        min_ones_d = min_ones_q;
        w_key_ack  = 1'b0;
        w_key_rej  = 1'b0;
        w_digits   = w_key_sync[NUM_DIGIT_KEYS-1:0];
        w_nonzero  = (sec_ones_q != '0) || (sec_tens_q != '0) || (min_ones_q != '0);

        unique case (state_q)
            ST_IDLE: begin
                if (bus.entry_en && w_key_any) state_d = ST_DEBOUNCE;
            end
            ST_DEBOUNCE: begin
                if (!bus.entry_en || !w_key_any) begin
                    state_d = ST_IDLE;
                end else if (w_press_stable) begin
                    state_d = ST_WAIT_RELEASE;
                    if (w_key_sync[KEY_CLEAR]) begin
                        sec_ones_d = '0;
                        sec_tens_d = '0;
                        min_ones_d = '0;
                    end else if (w_key_sync[KEY_START]) begin
                        if (w_nonzero) state_d   = ST_LOAD;
                        else           w_key_rej = 1'b1;
                    end else if (!is_onehot(w_digits)
                                 || (sec_ones_q > digit_t'(SEC_TENS_MAX))) begin
                        // Rejecting a shift when sec_ones > 5 keeps sec_tens a
                        // valid mod-6 value.
                        w_key_rej = 1'b1;
                    end else begin
                        min_ones_d = sec_tens_q;
                        sec_tens_d = sec_ones_q;
                        sec_ones_d = key_to_digit(w_digits);
                        w_key_ack  = 1'b1;
                    end
                end
            end
            ST_WAIT_RELEASE: begin
                if (w_release_stable) state_d = ST_IDLE;
            end
            ST_LOAD: begin
                // Digits stay stable while loadn is low and clear afterwards.
                state_d    = ST_WAIT_RELEASE;
                sec_ones_d = '0;
                sec_tens_d = '0;
                min_ones_d = '0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.sec_ones = sec_ones_q;
    assign bus.sec_tens = sec_tens_q;
    assign bus.min_ones = min_ones_q;
    assign bus.loadn    = (state_q != ST_LOAD);
    assign bus.key_ack  = w_key_ack;
    assign bus.key_rej  = w_key_rej;
    assign bus.nonzero  = w_nonzero;

endmodule : time_entry
`default_nettype wire

// File: tb/tb_time_entry.sv
`default_nettype none
// ============================================================================
//  Module      : tb_time_entry
//  Description : Directed self-checking bench for time_entry.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_time_entry;

    localparam logic [11:0] C_CLR   = 12'h400;
    localparam logic [11:0] C_START = 12'h800;

    logic clk;
    logic clrn;

    time_entry_if bus ();

    time_entry #(.DEBOUNCE_CYCLES(4)) dut (
        .clk  (clk),
        .clrn (clrn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Activity monitor, sampled on the falling edge.
    int          ack_cnt     = 0;
    int          rej_cnt     = 0;
    int          load_cnt    = 0;
    int          overlap_cnt = 0;
    int          run_low     = 0;
    int          max_run_low = 0;
    logic        post_pending = 1'b0;
    logic [11:0] lo_digits   = '0;
    logic [11:0] post_digits = '0;

    always @(negedge clk) begin
        if (bus.key_ack) ack_cnt++;
        if (bus.key_rej) rej_cnt++;
        if (bus.key_ack && bus.key_rej) overlap_cnt++;
        if (post_pending) begin
            post_digits  = {bus.min_ones, bus.sec_tens, bus.sec_ones};
            post_pending = 1'b0;
        end
        if (!bus.loadn) begin
            load_cnt++;
            run_low++;
            lo_digits    = {bus.min_ones, bus.sec_tens, bus.sec_ones};
            post_pending = 1'b1;
            if (run_low > max_run_low) max_run_low = run_low;
        end else begin
            run_low = 0;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] digits();
        return {bus.min_ones, bus.sec_tens, bus.sec_ones};
    endfunction

    function automatic logic [11:0] dkey(input int d);
        logic [11:0] one;
        one = 12'h001;
        return one << d;
    endfunction

    task automatic drive(input logic [11:0] k);
        bus.keypad    = k[9:0];
        bus.clear_key = k[10];
        bus.start_key = k[11];
    endtask

    // Hold a key combination for 10 cycles, then release for 10.
    task automatic press(input logic [11:0] k);
        @(negedge clk);
        drive(k);
        repeat (10) @(negedge clk);
        drive('0);
        repeat (10) @(negedge clk);
    endtask

    int a0, r0, l0;
    logic seen;

    initial begin
        clrn        = 1'b0;
        bus.entry_en = 1'b1;
        drive('0);
        repeat (3) @(negedge clk);
        check_eq("reset_digits",  32'(digits()),    32'h000);
        check_eq("reset_loadn",   32'(bus.loadn),   32'd1);
        check_eq("reset_ack_rej", 32'({bus.key_ack, bus.key_rej}), 32'd0);
        check_eq("reset_nonzero", 32'(bus.nonzero), 32'd0);
        clrn = 1'b1;
        repeat (3) @(negedge clk);

        // Enter 1,3,0
        a0 = ack_cnt; r0 = rej_cnt;
        press(dkey(1));
        check_eq("shift_1", 32'(digits()), 32'h001);
        press(dkey(3));
        press(dkey(0));
        check_eq("shift_130", 32'(digits()), 32'h130);
        check_eq("ack_x3", 32'(ack_cnt - a0), 32'd3);
        check_eq("rej_none", 32'(rej_cnt - r0), 32'd0);
        check_eq("nonzero_130", 32'(bus.nonzero), 32'd1);

        // Start with 1:30 loaded
        l0 = load_cnt;
        press(C_START);
        check_eq("load_once", 32'(load_cnt - l0), 32'd1);
        check_eq("load_digits", 32'(lo_digits), 32'h130);
        check_eq("post_load_zero", 32'(post_digits), 32'h000);
        check_eq("digits_after_load", 32'(digits()), 32'h000);

        // Start with all zero -> rejected, no load
        l0 = load_cnt; r0 = rej_cnt;
        press(C_START);
        check_eq("start_zero_rej", 32'(rej_cnt - r0), 32'd1);
        check_eq("start_zero_noload", 32'(load_cnt - l0), 32'd0);

        // 0,0,7 then 2 -> rejected
        press(dkey(7));
        check_eq("digits_007", 32'(digits()), 32'h007);
        a0 = ack_cnt; r0 = rej_cnt;
        press(dkey(2));
        check_eq("ones_gt5_rej", 32'(rej_cnt - r0), 32'd1);
        check_eq("ones_gt5_noack", 32'(ack_cnt - a0), 32'd0);
        check_eq("ones_gt5_digits", 32'(digits()), 32'h007);

        // Clear
        a0 = ack_cnt; r0 = rej_cnt;
        press(C_CLR);
        check_eq("clear_digits", 32'(digits()), 32'h000);
        check_eq("clear_no_pulse", 32'((ack_cnt - a0) + (rej_cnt - r0)), 32'd0);

        // Bounce: 2-cycle pulses never satisfy a 4-cycle debounce
        a0 = ack_cnt; r0 = rej_cnt;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); drive(dkey(3));
            repeat (2) @(negedge clk); drive('0);
            @(negedge clk);
        end
        repeat (12) @(negedge clk);
        check_eq("bounce_noack", 32'((ack_cnt - a0) + (rej_cnt - r0)), 32'd0);
        check_eq("bounce_digits", 32'(digits()), 32'h000);

        // Two digit keys together -> rejected, no shift
        press(dkey(2));
        r0 = rej_cnt; a0 = ack_cnt;
        press(dkey(4) | dkey(5));
        check_eq("multi_rej", 32'(rej_cnt - r0), 32'd1);
        check_eq("multi_noack", 32'(ack_cnt - a0), 32'd0);
        check_eq("multi_digits", 32'(digits()), 32'h002);

        // Keys ignored while entry disabled
        bus.entry_en = 1'b0;
        a0 = ack_cnt;
        press(dkey(5));
        check_eq("disabled_noack", 32'(ack_cnt - a0), 32'd0);
        check_eq("disabled_digits", 32'(digits()), 32'h002);
        bus.entry_en = 1'b1;
        repeat (3) @(negedge clk);

        // Async reset mid-debounce with 0,2,5
        press(C_CLR);
        press(dkey(2));
        press(dkey(5));
        check_eq("digits_025", 32'(digits()), 32'h025);
        a0 = ack_cnt;
        @(negedge clk);
        drive(dkey(8));
        repeat (4) @(negedge clk);
        #2 clrn = 1'b0;
        #1;
        check_eq("async_rst_digits", 32'(digits()), 32'h000);
        check_eq("async_rst_outs", 32'({bus.loadn, bus.key_ack, bus.key_rej, bus.nonzero}), 32'b1000);
        @(negedge clk);
        drive('0);
        repeat (3) @(negedge clk);
        clrn = 1'b1;
        repeat (12) @(negedge clk);
        check_eq("after_rst_noack", 32'(ack_cnt - a0), 32'd0);
        press(dkey(4));
        check_eq("after_rst_entry", 32'(digits()), 32'h004);

        // Reset during LOAD releases loadn at once
        @(negedge clk);
        drive(C_START);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (!bus.loadn) seen = 1'b1;
        end
        check_eq("load_seen", 32'(seen), 32'd1);
        #2 clrn = 1'b0;
        #1;
        check_eq("rst_in_load_loadn", 32'(bus.loadn), 32'd1);
        drive('0);
        repeat (3) @(negedge clk);
        clrn = 1'b1;
        repeat (3) @(negedge clk);

        check_eq("ack_rej_exclusive", 32'(overlap_cnt), 32'd0);
        check_eq("loadn_max_one_cycle", 32'(max_run_low), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_time_entry
`default_nettype wire
